// File: rtl/divider_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package divider_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;

    // Bit counter must hold 2*width down to 1.
    function automatic int cnt_width(input int width);
        return $clog2(2 * width + 1);
    endfunction

endpackage

// File: rtl/divider_step.sv
// One restoring-division step: shift in a dividend bit, compare, conditionally subtract.
module divider_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   partial_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   partial_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    assign shifted = {partial_in[WIDTH-1:0], bit_in};
    assign diff    = shifted - {1'b0, divisor};

    // A bit shifted out of the top means the true value already exceeds the divisor;
    // the wrapped difference is still exact because the value is below 2*divisor.
    assign q_bit       = partial_in[WIDTH] | (shifted >= {1'b0, divisor});
    assign partial_out = q_bit ? diff : shifted;

endmodule

// File: rtl/divider_seq.sv
// Sequential restoring divider: 2*WIDTH-bit dividend / WIDTH-bit divisor, one quotient bit per cycle.
module divider_seq
    import divider_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]     remainder,
    output logic                 div_by_zero
);

    localparam int DW = 2 * WIDTH;
    localparam int CW = cnt_width(WIDTH);

    div_state_t        state_reg, state_next;
    logic [CW-1:0]     count_reg, count_next;
    logic [DW-1:0]     dividend_reg, dividend_next;
    logic [WIDTH-1:0]  divisor_reg, divisor_next;
    logic [WIDTH:0]    partial_reg, partial_next;
    logic [DW-1:0]     quotient_reg, quotient_next;
    logic [WIDTH-1:0]  remainder_reg, remainder_next;
    logic              dbz_reg, dbz_next;

    logic [WIDTH:0]    step_partial;
    logic              step_q;

    divider_step #(.WIDTH(WIDTH)) u_step (
        .partial_in  (partial_reg),
        .bit_in      (dividend_reg[DW-1]),
        .divisor     (divisor_reg),
        .partial_out (step_partial),
        .q_bit       (step_q)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            count_reg     <= '0;
            dividend_reg  <= '0;
            divisor_reg   <= '0;
            partial_reg   <= '0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            dbz_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            dividend_reg  <= dividend_next;
            divisor_reg   <= divisor_next;
            partial_reg   <= partial_next;
            quotient_reg  <= quotient_next;
            remainder_reg <= remainder_next;
            dbz_reg       <= dbz_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        count_next     = count_reg;
        dividend_next  = dividend_reg;
        divisor_next   = divisor_reg;
        partial_next   = partial_reg;
        quotient_next  = quotient_reg;
        remainder_next = remainder_reg;
        dbz_next       = dbz_reg;

        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    dividend_next = dividend;
                    divisor_next  = divisor;
                    partial_next  = '0;
                    count_next    = CW'(DW);
                    if (divisor == '0) begin
                        state_next     = DONE;
                        quotient_next  = '1;
                        remainder_next = dividend[WIDTH-1:0];
                        dbz_next       = 1'b1;
                    end else begin
                        state_next = BUSY;
                    end
                end
            end
            BUSY: begin
                // The dividend register doubles as the quotient shift register.
                partial_next  = step_partial;
                dividend_next = {dividend_reg[DW-2:0], step_q};
                count_next    = count_reg - CW'(1);
                if (count_reg == CW'(1)) begin
                    state_next     = DONE;
                    quotient_next  = {dividend_reg[DW-2:0], step_q};
                    remainder_next = step_partial[WIDTH-1:0];
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                    dbz_next   = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign in_ready    = (state_reg == IDLE);
    assign out_valid   = (state_reg == DONE);
    assign quotient    = quotient_reg;
    assign remainder   = remainder_reg;
    assign div_by_zero = dbz_reg;

endmodule
